// File: rtl/i2c_target_regs.sv
// I2C target with four shared byte registers and a pointer, also reachable from a Wishbone slave port.
// state      | meaning
// S_IDLE     | bus ignored until START
// S_ADDR     | shifting in address + R/W
// S_ADDR_ACK | driving address ACK
// S_RX       | shifting in a data byte (first byte loads PTR)
// S_RX_ACK   | driving data ACK
// S_TX       | shifting out R[PTR]
// S_TX_ACKCHK| sampling master ACK/NACK
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR = 7'h42
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [2:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  input  logic        scl_pad_i,
  input  logic        sda_pad_i,
  output logic        sda_pad_o,
  output logic        sda_padoen_o,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACKCHK
  } state_t;

  state_t      state_q;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_prev_q, sda_prev_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        rw_q, first_q, oen_q;
  logic [1:0]  ptr_q;
  logic        i2c_wr_q;
  logic [7:0]  i2c_wr_data_q;
  logic [1:0]  i2c_wr_idx_q;
  logic [7:0]  regs_q [4];
  logic        wr_flag_q, ack_q;
  logic [31:0] dat_q, rd_data_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, wb_req, busy;
  logic unused_dat;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign busy      = (state_q != S_IDLE);
  assign wb_req    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign unused_dat = ^wb_dat_i[31:8];

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_pad_i};
      sda_sync_q <= {sda_sync_q[0], sda_pad_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'd0;
      rw_q          <= 1'b0;
      first_q       <= 1'b0;
      ptr_q         <= 2'd0;
      oen_q         <= 1'b1;
      i2c_wr_q      <= 1'b0;
      i2c_wr_data_q <= 8'd0;
      i2c_wr_idx_q  <= 2'd0;
    end else begin
      i2c_wr_q <= 1'b0;
      if (stop_det) begin
        state_q <= S_IDLE;
        oen_q   <= 1'b1;
      end else if (start_det) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= 4'd0;
        oen_q     <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_ADDR: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              if (shift_q[7:1] == I2C_ADDR) begin
                state_q <= S_ADDR_ACK;
                rw_q    <= shift_q[0];
                oen_q   <= 1'b0;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (rw_q) begin
                state_q   <= S_TX;
                shift_q   <= regs_q[ptr_q];
                oen_q     <= regs_q[ptr_q][7];
                bit_cnt_q <= 4'd1;
              end else begin
                state_q   <= S_RX;
                first_q   <= 1'b1;
                oen_q     <= 1'b1;
                bit_cnt_q <= 4'd0;
              end
            end
          end
          S_RX: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              state_q <= S_RX_ACK;
              oen_q   <= 1'b0;
              if (first_q) begin
                ptr_q   <= shift_q[1:0];
                first_q <= 1'b0;
              end else begin
                i2c_wr_q      <= 1'b1;
                i2c_wr_data_q <= shift_q;
                i2c_wr_idx_q  <= ptr_q;
                ptr_q         <= ptr_q + 2'd1;
              end
            end
          end
          S_RX_ACK: begin
            if (scl_fall) begin
              state_q   <= S_RX;
              oen_q     <= 1'b1;
              bit_cnt_q <= 4'd0;
            end
          end
          S_TX: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                state_q   <= S_TX_ACKCHK;
                oen_q     <= 1'b1;
                bit_cnt_q <= 4'd0;
                ptr_q     <= ptr_q + 2'd1;
              end else begin
                oen_q     <= shift_q[6];
                shift_q   <= {shift_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          S_TX_ACKCHK: begin
            // bit_cnt_q==1 marks "ACK seen, next byte starts at the coming falling edge"
            if (scl_rise) begin
              if (sda_s) state_q <= S_IDLE;
              else       bit_cnt_q <= 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd1) begin
              state_q   <= S_TX;
              shift_q   <= regs_q[ptr_q];
              oen_q     <= regs_q[ptr_q][7];
              bit_cnt_q <= 4'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rd_data_d = 32'd0;
    case (wb_adr_i)
      3'd0, 3'd1, 3'd2, 3'd3: rd_data_d[7:0] = regs_q[wb_adr_i[1:0]];
      3'd4:                   rd_data_d = {22'd0, ptr_q, 6'd0, wr_flag_q, busy};
      default:                rd_data_d = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= 8'd0;
      wr_flag_q <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= 32'd0;
    end else begin
      ack_q <= wb_req;
      if (wb_req) dat_q <= rd_data_d;
      if (wb_req && wb_we_i && !wb_adr_i[2]) regs_q[wb_adr_i[1:0]] <= wb_dat_i[7:0];
      // I2C write placed last so it wins a same-register collision
      if (i2c_wr_q) regs_q[i2c_wr_idx_q] <= i2c_wr_data_q;
      if (i2c_wr_q) wr_flag_q <= 1'b1;
      else if (wb_req && wb_we_i && wb_adr_i == 3'd4 && wb_dat_i[1]) wr_flag_q <= 1'b0;
    end
  end

  assign wb_dat_o     = dat_q;
  assign wb_ack_o     = ack_q;
  assign wb_err_o     = 1'b0;
  assign wb_rty_o     = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_q;
  assign irq_o        = wr_flag_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master plus Wishbone master, scoreboard-checked.
module tb_i2c_target_regs;
  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  wb_adr = 3'd0;
  logic [31:0] wb_dat_w = 32'd0;
  logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic        scl_m = 1'b1, sda_m = 1'b1;
  logic        sda_line, sda_pad_o, sda_padoen_o, irq_o;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

  i2c_target_regs #(.I2C_ADDR(7'h42)) dut (
    .wb_clk(clk), .wb_rst(rst),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .scl_pad_i(scl_m), .sda_pad_i(sda_line), .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
    .irq_o(irq_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_q.push_back(val);
    tag_q.push_back(tag);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else check(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; qwait();
    scl_m = 1'b1; qwait(); qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    b = sda_line; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] data, input logic exp_ack, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(data[i]);
    sb_push(tag, {31'd0, exp_ack});
    read_bit(a);
    sb_pop({31'd0, a});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic nack, input string tag);
    logic [7:0] d;
    logic b;
    sb_push(tag, {24'd0, exp});
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    sb_pop({24'd0, d});
    write_bit(nack);
  endtask

  task automatic wb_xfer(input logic [2:0] adr, input logic we, input logic [31:0] dat,
                         output logic [31:0] rdata);
    logic got;
    got = 1'b0;
    @(negedge clk);
    wb_adr = adr; wb_we = we; wb_dat_w = dat; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wb_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("wb_ack_timeout", 32'd0, 32'd1);
    rdata = wb_dat_o;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [31:0] dat);
    logic [31:0] r;
    wb_xfer(adr, 1'b1, dat, r);
  endtask

  task automatic wb_read(input logic [2:0] adr, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    sb_push(tag, exp);
    wb_xfer(adr, 1'b0, 32'd0, r);
    sb_pop(r);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_oen", {31'd0, sda_padoen_o}, 32'd1);
    check("rst_pad_o", {31'd0, sda_pad_o}, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_err_rty", {30'd0, wb_err_o, wb_rty_o}, 32'd0);
    wb_read(3'd4, 32'h0, "rst_status");
    wb_read(3'd0, 32'h0, "rst_r0");

    // I2C write: ptr 1, then 0xAA, 0xBB
    i2c_start();
    write_byte(8'h84, 1'b0, "w_addr_ack");
    write_byte(8'h01, 1'b0, "w_ptr_ack");
    write_byte(8'hAA, 1'b0, "w_d0_ack");
    write_byte(8'hBB, 1'b0, "w_d1_ack");
    i2c_stop();
    qwait();
    check("w_irq", {31'd0, irq_o}, 32'd1);
    wb_read(3'd1, 32'hAA, "w_r1");
    wb_read(3'd2, 32'hBB, "w_r2");
    wb_read(3'd0, 32'h00, "w_r0");
    wb_read(3'd4, 32'h302, "w_status");

    // clear wr_flag
    wb_write(3'd4, 32'h2);
    @(negedge clk);
    check("clr_irq", {31'd0, irq_o}, 32'd0);
    wb_read(3'd4, 32'h300, "clr_status");
    wb_read(3'd5, 32'h0, "adr5_zero");

    // read back through I2C with repeated START, wrapping PTR 3 -> 0
    wb_write(3'd3, 32'h5C);
    wb_write(3'd0, 32'h3E);
    i2c_start();
    write_byte(8'h84, 1'b0, "r_waddr_ack");
    write_byte(8'h03, 1'b0, "r_ptr_ack");
    i2c_start();
    write_byte(8'h85, 1'b0, "r_raddr_ack");
    read_byte(8'h5C, 1'b0, "r_byte0");
    read_byte(8'h3E, 1'b1, "r_byte1");
    qwait();
    check("r_sda_released", {31'd0, sda_padoen_o}, 32'd1);
    i2c_stop();
    check("r_irq", {31'd0, irq_o}, 32'd0);
    wb_read(3'd4, 32'h100, "r_status");

    // wrong address: no ACK, data ignored
    i2c_start();
    write_byte(8'h86, 1'b1, "bad_addr_nack");
    qwait();
    wb_read(3'd4, 32'h100, "bad_busy");
    write_byte(8'h55, 1'b1, "bad_data_nack");
    i2c_stop();
    wb_read(3'd1, 32'hAA, "bad_r1");
    wb_read(3'd0, 32'h3E, "bad_r0");

    // held request: ack alternates
    @(negedge clk);
    wb_adr = 3'd1; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ack_pulse", {31'd0, wb_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i == 0) check("ack_pulse_dat", wb_dat_o, 32'hAA);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);

    // reset while transmitting a 0 bit
    i2c_start();
    write_byte(8'h84, 1'b0, "t_waddr_ack");
    write_byte(8'h00, 1'b0, "t_ptr_ack");
    i2c_start();
    write_byte(8'h85, 1'b0, "t_raddr_ack");
    check("t_sda_driven", {31'd0, sda_padoen_o}, 32'd0);
    #2 rst = 1'b1;
    #1 check("t_rst_release", {31'd0, sda_padoen_o}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read_byte(8'hFF, 1'b1, "t_ignored");
    i2c_stop();
    wb_read(3'd4, 32'h0, "t_status");
    for (int i = 0; i < 4; i++) wb_read(i[2:0], 32'h0, "t_reg_zero");

    // fresh transaction after reset, PTR wraps on write
    i2c_start();
    write_byte(8'h84, 1'b0, "n_addr_ack");
    write_byte(8'h03, 1'b0, "n_ptr_ack");
    write_byte(8'h11, 1'b0, "n_d0_ack");
    write_byte(8'h22, 1'b0, "n_d1_ack");
    i2c_stop();
    qwait();
    wb_read(3'd3, 32'h11, "n_r3");
    wb_read(3'd0, 32'h22, "n_r0");
    wb_read(3'd4, 32'h102, "n_status");
    check("n_irq", {31'd0, irq_o}, 32'd1);

    if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
